// File: rtl/lr_sample_feeder.sv
// ============================================================================
// lr_sample_feeder : streams a small Q6.10 dataset to the trainer, multi-epoch
// Rev 1.0
// ============================================================================
`default_nettype none

module lr_sample_feeder #(
   parameter int NSAMP = 8,
   parameter int AW    = 3,
   parameter int DW    = 16,
   parameter int EW    = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic [2:0]    wr_sel,
   input  logic [DW-1:0] wr_data,
   input  logic [AW:0]   num_samples,
   input  logic [EW-1:0] num_epochs,
   input  logic          start,
   input  logic          abort,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] out_dp0,
   output logic [DW-1:0] out_dp1,
   output logic [DW-1:0] out_dp2,
   output logic [DW-1:0] out_dp3,
   output logic [DW-1:0] out_y,
   output logic [AW-1:0] out_idx,
   output logic          out_last,
   output logic [EW-1:0] epoch_cnt,
   output logic          busy,
   output logic          done,
   output logic          err
);

   typedef enum logic [0:0] {IDLE = 1'b0, RUN = 1'b1} state_t;

   localparam logic [AW:0] NSAMP_W = (AW+1)'(NSAMP);

   state_t        state;
   logic [AW:0]   n_reg;
   logic [EW-1:0] ne_reg;

   logic [DW-1:0] mem_dp0 [NSAMP];
   logic [DW-1:0] mem_dp1 [NSAMP];
   logic [DW-1:0] mem_dp2 [NSAMP];
   logic [DW-1:0] mem_dp3 [NSAMP];
   logic [DW-1:0] mem_y   [NSAMP];

   logic          at_last;
   logic [AW-1:0] ld_addr;
   logic [EW:0]   epoch_inc;
   logic          run_end;
   logic          cfg_bad;
   logic          hs;

   assign at_last   = ({1'b0, out_idx} == (n_reg - 1'b1));
   assign out_last  = out_valid & at_last;
   assign hs        = out_valid & out_ready;
   // Loads come from sample 0 on start and on epoch wrap, otherwise the next index
   assign ld_addr   = (state == RUN && !at_last) ? out_idx + 1'b1 : '0;
   assign epoch_inc = {1'b0, epoch_cnt} + 1'b1;
   assign run_end   = (epoch_inc == {1'b0, ne_reg});
   assign cfg_bad   = (num_samples == '0) || (num_samples > NSAMP_W) || (num_epochs == '0);

   // Dataset register file: not reset, writable only while idle
   always_ff @(posedge clk) begin
      if (wr_en && state == IDLE && ({1'b0, wr_addr} < NSAMP_W)) begin
         case (wr_sel)
            3'd0:    mem_dp0[wr_addr] <= wr_data;
            3'd1:    mem_dp1[wr_addr] <= wr_data;
            3'd2:    mem_dp2[wr_addr] <= wr_data;
            3'd3:    mem_dp3[wr_addr] <= wr_data;
            3'd4:    mem_y[wr_addr]   <= wr_data;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         n_reg     <= '0;
         ne_reg    <= '0;
         out_valid <= 1'b0;
         out_dp0   <= '0;
         out_dp1   <= '0;
         out_dp2   <= '0;
         out_dp3   <= '0;
         out_y     <= '0;
         out_idx   <= '0;
         epoch_cnt <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
      end else if (abort) begin
         state     <= IDLE;
         out_valid <= 1'b0;
         busy      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  if (cfg_bad) begin
                     err  <= 1'b1;
                     done <= 1'b0;
                  end else begin
                     n_reg     <= num_samples;
                     ne_reg    <= num_epochs;
                     done      <= 1'b0;
                     err       <= 1'b0;
                     epoch_cnt <= '0;
                     out_idx   <= '0;
                     out_dp0   <= mem_dp0[ld_addr];
                     out_dp1   <= mem_dp1[ld_addr];
                     out_dp2   <= mem_dp2[ld_addr];
                     out_dp3   <= mem_dp3[ld_addr];
                     out_y     <= mem_y[ld_addr];
                     out_valid <= 1'b1;
                     busy      <= 1'b1;
                     state     <= RUN;
                  end
               end
            end
            RUN: begin
               if (hs) begin
                  out_idx <= ld_addr;
                  if (at_last) begin
                     if (!(&epoch_cnt)) epoch_cnt <= epoch_inc[EW-1:0];
                  end
                  if (at_last && run_end) begin
                     out_valid <= 1'b0;
                     busy      <= 1'b0;
                     done      <= 1'b1;
                     state     <= IDLE;
                  end else begin
                     out_dp0 <= mem_dp0[ld_addr];
                     out_dp1 <= mem_dp1[ld_addr];
                     out_dp2 <= mem_dp2[ld_addr];
                     out_dp3 <= mem_dp3[ld_addr];
                     out_y   <= mem_y[ld_addr];
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: doc/lr_sample_feeder.md
# lr_sample_feeder

Upstream training-data sequencer for the 4-weight linear-regression trainer. It holds a small dataset of Q6.10 feature vectors (dp0..dp3) and targets (y) in an internal register file. On `start` it streams the samples to the trainer over a valid/ready handshake, wrapping over the dataset for a programmed number of epochs, then flags completion. It replaces the trainer's hard-coded single sample with a real multi-sample, multi-epoch feed.

## Interface
- NSAMP, 8: dataset depth (samples); power of two not required
- AW, 3: sample index width, ceil(log2(NSAMP))
- DW, 16: data width, signed Q6.10 (0x0400 = 1.0)
- EW, 16: epoch counter width

- CLK  in  1  clock; all state changes on rising edge
- RST_N  in  1  reset; one clock; reset is asynchronous and active-low
- wr_en  in  1  dataset write strobe; honoured only when busy=0
- wr_addr  in  AW  sample index written
- wr_sel  in  3  field select: 0..3 = dp0..dp3, 4 = y, 5..7 = ignored
- wr_data  in  DW  field value
- num_samples  in  AW+1  samples per epoch, sampled at start; legal 1..NSAMP
- num_epochs  in  EW  epochs to run, sampled at start; legal ≥1
- start  in  1  single-cycle run request; honoured only when busy=0
- abort  in  1  stop run, return to IDLE
- out_valid  out  1  sample presented
- out_ready  in  1  trainer accepts sample
- out_dp0..out_dp3  out  DW each  feature values
- out_y  out  DW  target
- out_idx  out  AW  index of presented sample
- out_last  out  1  presented sample is last of its epoch
- epoch_cnt  out  EW  completed epochs in current/last run
- busy  out  1  high in RUN
- done  out  1  sticky: run finished normally; cleared by next accepted start
- err  out  1  sticky: last start had illegal config; cleared by next accepted start

## Operation
- FSM states IDLE, RUN. Reset → IDLE; all outputs 0, internal index 0. Register file is not reset.
- IDLE: writes go to mem[wr_addr].field. Out-of-range wr_addr (≥NSAMP) ignored. On start with abort=0:
  - illegal config (num_samples=0 or >NSAMP, or num_epochs=0): err=1, done=0, stay IDLE;
  - else latch config, clear done/err/epoch_cnt, load output regs from sample 0, set out_valid=1, go RUN.
- RUN: outputs registered and held stable while out_valid & !out_ready. wr_en and start ignored.
- Handshake (out_valid & out_ready):
  - idx < n-1: idx+1, outputs load mem[idx+1];
  - idx = n-1: epoch_cnt+1, idx wraps to 0. If epoch_cnt+1 = num_epochs: out_valid=0, busy=0, done=1, go IDLE; else outputs load mem[0].
- out_last = (out_idx = n-1), combinational from registered idx.
- abort (any state, highest priority over start/handshake): next edge out_valid=0, busy=0, IDLE; done unchanged (stays 0 for aborted run), epoch_cnt holds.
- epoch_cnt saturates at all-ones; never wraps.
- RST_N low mid-run: immediate return to IDLE, outputs 0; dataset contents retained.

## Timing
- start at edge t → out_valid=1, out_idx=0, data of sample 0 visible after edge t.
- Throughput 1 sample/cycle with out_ready held high; no bubbles, including across epoch wrap.
- Last handshake at edge t → out_valid=0, done=1, busy=0 after edge t.
- Write at edge t visible in a sample loaded at edge t+1 or later.
- A new start is accepted the cycle after done is set.

## Test plan
- Load sample 0 = {0x0800,0x1000,0x0C00,0x1800}, y=0x3C00; num_samples=1, num_epochs=3, out_ready=1 → exactly 3 handshakes, all identical data, out_last=1 each, epoch_cnt=3, done=1 after third.
- Load 4 distinct samples, num_samples=4, num_epochs=2, out_ready toggling 1/0 each cycle → out_idx sequence 0,1,2,3,0,1,2,3; data stable during stalls; out_last only at idx 3; done after 8 handshakes.
- num_samples=0 (then num_epochs=0) with start → err=1, out_valid stays 0, busy=0; next legal start clears err.
- Abort after 5 handshakes of a 4×2 run → out_valid=0 next cycle, done=0, epoch_cnt=1; wr_en during RUN leaves mem unchanged (verified on rerun).
- RST_N pulsed low asynchronously mid-run → outputs 0 without clock edge; restart streams previously loaded data correctly.
- start asserted during RUN and start+abort same cycle in IDLE → both ignored, no state change.
